// File: rtl/mem_scheduler.sv
// Arbitrates three byte-wide memory ports (ifetch, dread, dwrite) onto one SPI master.
// Each access is one serial frame: a single-cycle send pulse, then a wait for spi_done, then an ack.
module mem_scheduler #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        ifetch_req,
    input  logic [15:0] ifetch_addr,
    output logic        ifetch_ack,
    output logic [7:0]  ifetch_data,

    input  logic        dread_req,
    input  logic [15:0] dread_addr,
    output logic        dread_ack,
    output logic [7:0]  dread_data,

    input  logic        dwrite_req,
    input  logic [15:0] dwrite_addr,
    input  logic [7:0]  dwrite_wdata,
    output logic        dwrite_ack,

    output logic [31:0] spi_write_data,
    output logic [2:0]  spi_write_len,
    output logic        spi_read_len,
    output logic        spi_send,
    input  logic        spi_done,
    input  logic [7:0]  spi_read_data,

    output logic        prog_cs_n,
    output logic        data_cs_n,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {PORT_IF, PORT_RD, PORT_WR} port_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    port_t       port_q, port_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  starve_q, starve_d;
    logic        turn_q, turn_d;
    logic [7:0]  ifetch_data_q, ifetch_data_d;
    logic [7:0]  dread_data_q, dread_data_d;

    logic        grant_valid;
    port_t       grant_port;

    // The IDLE cycle right after an ack grants nothing, so the just-served requester
    // may drop its req one cycle late without being granted twice.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = PORT_IF;
        if (state_q == IDLE && !turn_q) begin
            if (ifetch_req && starve_q == STARVE_LIM) begin
                grant_valid = 1'b1;
                grant_port  = PORT_IF;
            end else if (dwrite_req) begin
                grant_valid = 1'b1;
                grant_port  = PORT_WR;
            end else if (dread_req) begin
                grant_valid = 1'b1;
                grant_port  = PORT_RD;
            end else if (ifetch_req) begin
                grant_valid = 1'b1;
                grant_port  = PORT_IF;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        starve_d      = starve_q;
        turn_d        = 1'b0;
        ifetch_data_d = ifetch_data_q;
        dread_data_d  = dread_data_q;

        case (state_q)
            IDLE: begin
                if (!ifetch_req) begin
                    starve_d = 4'd0;
                end else if (grant_valid) begin
                    if (grant_port == PORT_IF) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
                if (grant_valid) begin
                    state_d = ISSUE;
                    port_d  = grant_port;
                    wdata_d = 8'h00;
                    case (grant_port)
                        PORT_WR: begin
                            addr_d  = dwrite_addr;
                            wdata_d = dwrite_wdata;
                        end
                        PORT_RD: addr_d = dread_addr;
                        default: addr_d = ifetch_addr;
                    endcase
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (spi_done) begin
                    state_d = ACK;
                    if (port_q == PORT_IF) begin
                        ifetch_data_d = spi_read_data;
                    end else if (port_q == PORT_RD) begin
                        dread_data_d = spi_read_data;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
                turn_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            port_q        <= PORT_IF;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            starve_q      <= 4'd0;
            turn_q        <= 1'b0;
            ifetch_data_q <= 8'h00;
            dread_data_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            starve_q      <= starve_d;
            turn_q        <= turn_d;
            ifetch_data_q <= ifetch_data_d;
            dread_data_q  <= dread_data_d;
        end
    end

    // Frame fields and chip selects are live only while the frame is on the wire.
    always_comb begin
        spi_write_data = 32'h0000_0000;
        spi_write_len  = 3'd0;
        spi_read_len   = 1'b0;
        prog_cs_n      = 1'b1;
        data_cs_n      = 1'b1;
        if (state_q == ISSUE || state_q == WAIT) begin
            if (port_q == PORT_WR) begin
                spi_write_data = {8'h02, addr_q, wdata_q};
                spi_write_len  = 3'd4;
            end else begin
                spi_write_data = {8'h03, addr_q, 8'h00};
                spi_write_len  = 3'd3;
                spi_read_len   = 1'b1;
            end
            if (port_q == PORT_IF) begin
                prog_cs_n = 1'b0;
            end else begin
                data_cs_n = 1'b0;
            end
        end
    end

    assign spi_send    = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign ifetch_ack  = (state_q == ACK) && (port_q == PORT_IF);
    assign dread_ack   = (state_q == ACK) && (port_q == PORT_RD);
    assign dwrite_ack  = (state_q == ACK) && (port_q == PORT_WR);
    assign ifetch_data = ifetch_data_q;
    assign dread_data  = dread_data_q;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed self-checking bench for mem_scheduler: single transactions, priority,
// starvation escape, late req drop, stray spi_done and mid-transaction reset.
module tb_mem_scheduler;

    logic        clock;
    logic        reset_n;
    logic        ifetch_req;
    logic [15:0] ifetch_addr;
    logic        ifetch_ack;
    logic [7:0]  ifetch_data;
    logic        dread_req;
    logic [15:0] dread_addr;
    logic        dread_ack;
    logic [7:0]  dread_data;
    logic        dwrite_req;
    logic [15:0] dwrite_addr;
    logic [7:0]  dwrite_wdata;
    logic        dwrite_ack;
    logic [31:0] spi_write_data;
    logic [2:0]  spi_write_len;
    logic        spi_read_len;
    logic        spi_send;
    logic        spi_done;
    logic [7:0]  spi_read_data;
    logic        prog_cs_n;
    logic        data_cs_n;
    logic        busy;

    int testsRun;
    int testsFailed;
    logic monEnable;

    mem_scheduler #(.STARVE_MAX(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ifetch_req(ifetch_req),
        .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack),
        .ifetch_data(ifetch_data),
        .dread_req(dread_req),
        .dread_addr(dread_addr),
        .dread_ack(dread_ack),
        .dread_data(dread_data),
        .dwrite_req(dwrite_req),
        .dwrite_addr(dwrite_addr),
        .dwrite_wdata(dwrite_wdata),
        .dwrite_ack(dwrite_ack),
        .spi_write_data(spi_write_data),
        .spi_write_len(spi_write_len),
        .spi_read_len(spi_read_len),
        .spi_send(spi_send),
        .spi_done(spi_done),
        .spi_read_data(spi_read_data),
        .prog_cs_n(prog_cs_n),
        .data_cs_n(data_cs_n),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic ifReq, input logic rdReq, input logic wrReq);
        ifetch_req = ifReq;
        dread_req  = rdReq;
        dwrite_req = wrReq;
    endtask

    task automatic checkFrame(input string tag, input logic [31:0] data, input logic [2:0] wlen,
                              input logic rlen, input logic send, input logic pcs, input logic dcs,
                              input logic bsy);
        checkOutput({tag, ".data"}, spi_write_data, data);
        checkOutput({tag, ".wlen"}, {29'd0, spi_write_len}, {29'd0, wlen});
        checkOutput({tag, ".rlen"}, {31'd0, spi_read_len}, {31'd0, rlen});
        checkOutput({tag, ".send"}, {31'd0, spi_send}, {31'd0, send});
        checkOutput({tag, ".prog_cs_n"}, {31'd0, prog_cs_n}, {31'd0, pcs});
        checkOutput({tag, ".data_cs_n"}, {31'd0, data_cs_n}, {31'd0, dcs});
        checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    endtask

    task automatic checkAcks(input string tag, input logic [2:0] expected);
        checkOutput({tag, ".acks"}, {29'd0, ifetch_ack, dread_ack, dwrite_ack}, {29'd0, expected});
    endtask

    // Advance until the DUT raises spi_send, with a cycle budget.
    task automatic waitIssue(input string tag);
        int n;
        n = 0;
        tick();
        while (!spi_send && n < 8) begin
            tick();
            n++;
        end
        checkOutput({tag, ".issue"}, {31'd0, spi_send}, 32'd1);
    endtask

    // From an ISSUE-cycle negedge: WAIT with spi_done, then stop at the ACK-cycle negedge.
    task automatic finishTxn(input logic [7:0] rdata);
        tick();
        spi_done      = 1'b1;
        spi_read_data = rdata;
        tick();
        spi_done      = 1'b0;
        spi_read_data = 8'h00;
    endtask

    always @(negedge clock) begin
        if (monEnable) begin
            checkOutput("cs_never_both_low", {31'd0, prog_cs_n | data_cs_n}, 32'd1);
            checkOutput("ack_at_most_one",
                        {31'd0, (({1'b0, ifetch_ack} + {1'b0, dread_ack} + {1'b0, dwrite_ack}) > 2'd1)},
                        32'd0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int writes;
        logic gotIfetch;

        testsRun      = 0;
        testsFailed   = 0;
        monEnable     = 1'b0;
        reset_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        ifetch_addr   = 16'h0000;
        dread_addr    = 16'h0000;
        dwrite_addr   = 16'h0000;
        dwrite_wdata  = 8'h00;
        spi_done      = 1'b0;
        spi_read_data = 8'h00;

        tick();
        tick();
        checkFrame("reset", 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkAcks("reset", 3'b000);
        checkOutput("reset.ifetch_data", {24'd0, ifetch_data}, 32'h00);
        checkOutput("reset.dread_data", {24'd0, dread_data}, 32'h00);
        reset_n   = 1'b1;
        monEnable = 1'b1;

        // Single instruction fetch at minimum latency
        ifetch_addr = 16'h1234;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkFrame("if_issue", 32'h03123400, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkFrame("if_wait", 32'h03123400, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        spi_done      = 1'b1;
        spi_read_data = 8'h2B;
        tick();
        checkFrame("if_ack", 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkAcks("if_ack", 3'b100);
        checkOutput("if_ack.ifetch_data", {24'd0, ifetch_data}, 32'h2B);
        spi_done      = 1'b0;
        spi_read_data = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkAcks("if_after", 3'b000);
        checkOutput("if_after.busy", {31'd0, busy}, 32'd0);
        checkOutput("if_after.ifetch_data", {24'd0, ifetch_data}, 32'h2B);
        tick();

        // Simultaneous write and read: write wins, read follows
        dwrite_addr  = 16'h0010;
        dwrite_wdata = 8'hA5;
        dread_addr   = 16'h0010;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkFrame("wr_issue", 32'h020010A5, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkFrame("wr_wait", 32'h020010A5, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        spi_done      = 1'b1;
        spi_read_data = 8'hEE;
        tick();
        checkAcks("wr_ack", 3'b001);
        checkOutput("wr_ack.dread_data", {24'd0, dread_data}, 32'h00);
        spi_done      = 1'b0;
        spi_read_data = 8'h00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIssue("rd");
        checkFrame("rd_issue", 32'h03001000, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        finishTxn(8'h5A);
        checkAcks("rd_ack", 3'b010);
        checkOutput("rd_ack.dread_data", {24'd0, dread_data}, 32'h5A);
        checkOutput("rd_ack.ifetch_data", {24'd0, ifetch_data}, 32'h2B);

        // Requester keeps req high one cycle past its ack
        tick();
        checkOutput("late_drop.busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("no_dup.busy", {31'd0, busy}, 32'd0);
        spi_done      = 1'b1;
        spi_read_data = 8'h99;
        tick();
        checkOutput("stray_done.busy", {31'd0, busy}, 32'd0);
        checkAcks("stray_done", 3'b000);
        checkOutput("stray_done.dread_data", {24'd0, dread_data}, 32'h5A);
        spi_done      = 1'b0;
        spi_read_data = 8'h00;

        // Starvation escape: ifetch waits behind continuous writes
        ifetch_addr  = 16'h4000;
        dwrite_addr  = 16'h0020;
        dwrite_wdata = 8'h11;
        applyStimulus(1'b1, 1'b0, 1'b1);
        writes    = 0;
        gotIfetch = 1'b0;
        for (int g = 0; g < 6 && !gotIfetch; g++) begin
            waitIssue("starve");
            if (!prog_cs_n) begin
                gotIfetch = 1'b1;
            end else begin
                writes++;
                finishTxn(8'h00);
                checkOutput("starve.wr_ack", {31'd0, dwrite_ack}, 32'd1);
            end
        end
        checkOutput("starve.write_grants", writes, 32'd4);
        checkOutput("starve.if_frame", spi_write_data, 32'h03400000);
        finishTxn(8'h77);
        checkAcks("starve_if_ack", 3'b100);
        checkOutput("starve_if_ack.ifetch_data", {24'd0, ifetch_data}, 32'h77);
        waitIssue("starve_cleared");
        checkFrame("starve_cleared", 32'h02002011, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        finishTxn(8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset in the middle of a data read
        dread_addr = 16'h0ABC;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIssue("rst_rd");
        tick();
        checkOutput("rst_rd_wait.data_cs_n", {31'd0, data_cs_n}, 32'd0);
        reset_n = 1'b0;
        tick();
        checkFrame("rst_mid", 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkAcks("rst_mid", 3'b000);
        checkOutput("rst_mid.ifetch_data", {24'd0, ifetch_data}, 32'h00);
        checkOutput("rst_mid.dread_data", {24'd0, dread_data}, 32'h00);
        reset_n       = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        spi_done      = 1'b1;
        spi_read_data = 8'h44;
        tick();
        checkOutput("rst_done_ignored.busy", {31'd0, busy}, 32'd0);
        checkAcks("rst_done_ignored", 3'b000);
        checkOutput("rst_done_ignored.dread_data", {24'd0, dread_data}, 32'h00);
        spi_done      = 1'b0;
        spi_read_data = 8'h00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIssue("rst_retry");
        checkFrame("rst_retry", 32'h030ABC00, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        finishTxn(8'h3C);
        checkAcks("rst_retry_ack", 3'b010);
        checkOutput("rst_retry_ack.dread_data", {24'd0, dread_data}, 32'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();

        monEnable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
